// File: rtl/io_bus_ctrl_pkg.sv
// Shared definitions for the IO bus controller: word-address bit indices,
// STATUS register bit positions, TX FSM state type and a saturating increment.
package io_bus_ctrl_pkg;

    // One-hot word-address bit indices (wa = IO_mem_addr[15:2])
    localparam int WA_LEDS        = 0;
    localparam int WA_UART_DATA   = 1;
    localparam int WA_UART_STATUS = 2;

    // STATUS register bit positions
    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_DROP_LSB = 16;

    // Address bit that selects IO space in the core (write strobe arrives pre-gated)
    localparam int IO_SPACE_BIT = 22;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/io_bus_ctrl_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO, baud down-counter and TX FSM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// TX_IDLE  | line high, waiting for FIFO non-empty; pops head when present
// TX_START | start bit (0) for DIV cycles
// TX_DATA  | 8 data bits LSB first, DIV cycles each
// TX_STOP  | stop bit (1); at end pops next byte straight into START or idles
module io_uart_tx
    import io_bus_ctrl_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push,
    input  logic [7:0] i_byte,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_drop,
    output logic       o_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;
    logic w_bit_end;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_bit_end = (r_baud == '0);
    // A pop frees a slot in the same cycle, so a push onto a full FIFO is only
    // dropped when no pop happens alongside it.
    assign w_pop     = !w_empty && ((r_state == TX_IDLE) || (r_state == TX_STOP && w_bit_end));
    assign w_accept  = i_push && (!w_full || w_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_busy  = !w_empty || (r_state != TX_IDLE);
    assign o_drop  = i_push && !w_accept;
    assign o_tx    = r_tx;

    // FIFO storage, no reset needed: contents are only read when count says valid
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= i_byte;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // TX FSM with baud down-counter and registered serial output
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= BAUD_RELOAD;
                        r_tx    <= 1'b0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_baud  <= BAUD_RELOAD;
                        r_state <= TX_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_baud  <= BAUD_RELOAD;
                            r_tx    <= 1'b0;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO controller: one-hot word decode, LED register, UART TX with
// sticky overflow flag and read mux. Optional dropped-byte counter is enabled
// by defining IO_BUS_CTRL_DROP_CNT_EN.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int LED_W       = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      IO_mem_addr,
    input  logic [31:0]      IO_mem_wdata,
    input  logic             IO_mem_wr,
    output logic [31:0]      IO_mem_rdata,
    output logic [LED_W-1:0] LEDS,
    output logic             uart_tx,
    output logic             uart_busy
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;

    logic [13:0]      w_wa;
    logic             w_wr_leds;
    logic             w_wr_data;
    logic             w_wr_status;
    logic             w_clr_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_drop;
    logic [15:0]      w_drop_cnt;
    logic [31:0]      w_status;
    logic             w_unused;

    logic [LED_W-1:0] r_leds;
    logic             r_ovf;

    assign w_wa        = IO_mem_addr[15:2];
    assign w_wr_leds   = IO_mem_wr && w_wa[WA_LEDS];
    assign w_wr_data   = IO_mem_wr && w_wa[WA_UART_DATA];
    assign w_wr_status = IO_mem_wr && w_wa[WA_UART_STATUS];
    assign w_clr_ovf   = w_wr_status && IO_mem_wdata[ST_OVF];
    assign w_unused    = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], w_wa[13:3], IO_mem_wdata[31:8]};

    io_uart_tx #(
        .DIV        (DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_wr_data),
        .i_byte  (IO_mem_wdata[7:0]),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_busy  (w_busy),
        .o_drop  (w_drop),
        .o_tx    (uart_tx)
    );

    // LED register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_leds <= '0;
        else if (w_wr_leds) r_leds <= IO_mem_wdata[LED_W-1:0];
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
        else if (w_clr_ovf) r_ovf <= 1'b0;
    end

`ifdef IO_BUS_CTRL_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating dropped-byte counter, cleared together with ovf
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_drop_cnt <= '0;
        else if (w_drop) r_drop_cnt <= w_clr_ovf ? 16'd1 : sat_inc16(r_drop_cnt);
        else if (w_clr_ovf) r_drop_cnt <= '0;
    end

    assign w_drop_cnt = r_drop_cnt;
`else
    assign w_drop_cnt = 16'h0000;
`endif

    assign w_status = {w_drop_cnt, 12'h000, r_ovf, w_busy, w_full, w_empty};

    // Read mux: lowest selected word-address bit wins, nothing selected reads 0
    always_comb begin
        IO_mem_rdata = 32'h0;
        if (w_wa[WA_LEDS])             IO_mem_rdata = 32'(r_leds);
        else if (w_wa[WA_UART_DATA])   IO_mem_rdata = 32'h0;
        else if (w_wa[WA_UART_STATUS]) IO_mem_rdata = w_status;
    end

    assign LEDS      = r_leds;
    assign uart_busy = w_busy;

endmodule
